luma_hfilter_pipe: RTL and testbench



---
 rtl/hevc_interp_pkg.sv | 46 ++++
 rtl/luma_tap8.sv | 22 ++
 rtl/luma_hfilter_pipe.sv | 120 ++++++++++++
 tb/tb_luma_hfilter_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hevc_interp_pkg.sv
// Shared constants, coefficient table and arithmetic helpers for the
// HEVC luma interpolation datapath.
package hevc_interp_pkg;

    localparam int PIX_W    = 8;
    localparam int ROW_PIX  = 15;
    localparam int OUT_PIX  = 8;
    localparam int NUM_TAPS = 8;
    localparam int ROUND    = 32;
    localparam int SHIFT    = 6;
    localparam int SUM_W    = 17;

    typedef enum logic [1:0] {
        FRAC_INT = 2'd0,
        FRAC_Q   = 2'd1,
        FRAC_H   = 2'd2,
        FRAC_3Q  = 2'd3
    } frac_e;

    typedef logic signed [SUM_W-1:0] sum_t;

    // Rows indexed by fractional position, columns by tap number.
    localparam logic signed [7:0] LUMA_COEF [4][NUM_TAPS] = '{
        '{ 8'sd0,  8'sd0,   8'sd0,  8'sd64,  8'sd0,   8'sd0,  8'sd0,  8'sd0},
        '{-8'sd1,  8'sd4, -8'sd10,  8'sd58,  8'sd17, -8'sd5,  8'sd1,  8'sd0},
        '{-8'sd1,  8'sd4, -8'sd11,  8'sd40,  8'sd40, -8'sd11, 8'sd4, -8'sd1},
        '{ 8'sd0,  8'sd1,  -8'sd5,  8'sd17,  8'sd58, -8'sd10, 8'sd4, -8'sd1}
    };

    function automatic sum_t tap_product(logic [PIX_W-1:0] pix, logic signed [7:0] coef);
        return sum_t'($signed({1'b0, pix})) * sum_t'(coef);
    endfunction

    // Worst-case sums stay within 17 bits, so rounding cannot overflow.
    function automatic logic [PIX_W-1:0] round_clip(sum_t sum);
        sum_t rnd;
        rnd = (sum + sum_t'(ROUND)) >>> SHIFT;
        if (rnd < 0)
            return '0;
        else if (rnd > 255)
            return 8'd255;
        else
            return rnd[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/luma_tap8.sv
// One output pixel's 8-tap filter, split into low and high 4-tap partial sums
// so the final add can sit in its own pipeline stage.
module luma_tap8
    import hevc_interp_pkg::*;
(
    input  logic [NUM_TAPS*PIX_W-1:0] window,
    input  frac_e                     frac,
    output sum_t                      part_lo,
    output sum_t                      part_hi
);

    always_comb begin
        part_lo = '0;
        part_hi = '0;
        for (int t = 0; t < NUM_TAPS/2; t++) begin
            part_lo = part_lo + tap_product(window[t*PIX_W +: PIX_W], LUMA_COEF[frac][t]);
            part_hi = part_hi + tap_product(window[(t+NUM_TAPS/2)*PIX_W +: PIX_W],
                                            LUMA_COEF[frac][t+NUM_TAPS/2]);
        end
    end

endmodule

// File: rtl/luma_hfilter_pipe.sv
// Three-stage HEVC luma horizontal interpolator: row register, 4-tap partials,
// then final add/round/clip. The whole pipe freezes while the output is held.
module luma_hfilter_pipe
    import hevc_interp_pkg::*;
#(
    parameter int ROWS_PER_BLK = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ROW_PIX*PIX_W-1:0]   in_row,
    input  logic [1:0]                 in_frac,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [OUT_PIX*PIX_W-1:0]   out_pix,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       out_load_L
);

    localparam int CNT_W = (ROWS_PER_BLK > 1) ? $clog2(ROWS_PER_BLK) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS_PER_BLK - 1);

    logic                       stall;
    logic                       accept;
    logic                       row_first;
    logic                       row_last;
    logic [CNT_W-1:0]           row_cnt;
    frac_e                      frac_q;
    frac_e                      frac_eff;

    logic                       s1_valid;
    logic                       s1_last;
    logic [ROW_PIX*PIX_W-1:0]   s1_row;
    frac_e                      s1_frac;

    logic                       s2_valid;
    logic                       s2_last;
    sum_t                       s2_lo [OUT_PIX];
    sum_t                       s2_hi [OUT_PIX];

    sum_t                       tap_lo [OUT_PIX];
    sum_t                       tap_hi [OUT_PIX];
    logic [OUT_PIX*PIX_W-1:0]   pix_next;

    assign stall      = out_valid & ~out_ready;
    assign in_ready   = ~stall;
    assign accept     = in_valid & in_ready;
    assign row_first  = (row_cnt == '0);
    assign row_last   = (row_cnt == LAST_ROW);
    assign frac_eff   = row_first ? frac_e'(in_frac) : frac_q;
    assign out_load_L = ~(out_valid & out_ready);

    // The first row of a block uses in_frac directly and latches it for the rest.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_cnt <= '0;
            frac_q  <= FRAC_INT;
        end else if (accept) begin
            row_cnt <= row_last ? '0 : row_cnt + CNT_W'(1);
            if (row_first)
                frac_q <= frac_e'(in_frac);
        end
    end

    for (genvar i = 0; i < OUT_PIX; i++) begin : g_tap
        luma_tap8 u_tap (
            .window  (s1_row[i*PIX_W +: NUM_TAPS*PIX_W]),
            .frac    (s1_frac),
            .part_lo (tap_lo[i]),
            .part_hi (tap_hi[i])
        );
    end

    always_comb begin
        pix_next = '0;
        for (int i = 0; i < OUT_PIX; i++)
            pix_next[i*PIX_W +: PIX_W] = round_clip(s2_lo[i] + s2_hi[i]);
    end

    // Bubbles advance with the pipe; only valid rows overwrite stage data.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_row    <= '0;
            s1_frac   <= FRAC_INT;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            for (int i = 0; i < OUT_PIX; i++) begin
                s2_lo[i] <= '0;
                s2_hi[i] <= '0;
            end
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_pix   <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_row  <= in_row;
                s1_frac <= frac_eff;
                s1_last <= row_last;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                for (int i = 0; i < OUT_PIX; i++) begin
                    s2_lo[i] <= tap_lo[i];
                    s2_hi[i] <= tap_hi[i];
                end
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_pix  <= pix_next;
                out_last <= s2_last;
            end
        end
    end

endmodule

// File: tb/tb_luma_hfilter_pipe.sv
// Scoreboard bench for luma_hfilter_pipe: accepted rows push reference results,
// an independent monitor pops and compares every output transfer.
module tb_luma_hfilter_pipe;

    localparam int ROWS = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [119:0] in_row;
    logic [1:0]   in_frac;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  out_pix;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         out_load_L;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int stall_cnt = 0;
    int blk_row   = 0;
    int blk_frac  = 0;
    bit rand_done = 0;

    typedef struct {
        logic [63:0] pix;
        logic        last;
        int          acc_cyc;
        int          acc_stall;
    } exp_t;

    exp_t sb[$];

    luma_hfilter_pipe #(.ROWS_PER_BLK(ROWS)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_row     (in_row),
        .in_frac    (in_frac),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_pix    (out_pix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_load_L (out_load_L)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int coef(int frac, int t);
        int tbl [4][8];
        tbl = '{'{ 0, 0,   0, 64,  0,   0, 0,  0},
                '{-1, 4, -10, 58, 17,  -5, 1,  0},
                '{-1, 4, -11, 40, 40, -11, 4, -1},
                '{ 0, 1,  -5, 17, 58, -10, 4, -1}};
        return tbl[frac][t];
    endfunction

    // Reference filter: plain integer dot product, round, floor-shift, clip.
    function automatic logic [63:0] ref_filter(logic [119:0] row, int frac);
        logic [63:0] res;
        int          sum;
        int          v;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            sum = 0;
            for (int t = 0; t < 8; t++)
                sum += coef(frac, t) * int'(row[8*(i+t) +: 8]);
            v = (sum + 32) >>> 6;
            if (v < 0) v = 0;
            else if (v > 255) v = 255;
            res[8*i +: 8] = v[7:0];
        end
        return res;
    endfunction

    function automatic logic [119:0] rand_row(bit extremes);
        logic [119:0] r;
        r = '0;
        for (int k = 0; k < 15; k++)
            r[8*k +: 8] = extremes ? (($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0)
                                   : 8'($urandom);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Producer side of the scoreboard: model the block/frac rules per accepted row.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            blk_row = 0;
        end else if (in_valid && in_ready) begin
            if (blk_row == 0)
                blk_frac = int'(in_frac);
            e.pix       = ref_filter(in_row, blk_frac);
            e.last      = (blk_row == ROWS - 1);
            e.acc_cyc   = cyc;
            e.acc_stall = stall_cnt;
            sb.push_back(e);
            blk_row = (blk_row + 1) % ROWS;
        end
    end

    // Monitor: compare transfers, stall behaviour and post-reset output values.
    logic        prev_reset = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] held_pix   = '0;

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_reset) begin
                check_output("reset_out_valid", 64'(out_valid), 64'd0);
                check_output("reset_out_pix", out_pix, 64'd0);
                check_output("reset_out_last", 64'(out_last), 64'd0);
                check_output("reset_load_L", 64'(out_load_L), 64'd1);
            end
            if (out_valid && !out_ready) begin
                stall_cnt++;
                check_output("stall_in_ready", 64'(in_ready), 64'd0);
                check_output("stall_load_L", 64'(out_load_L), 64'd1);
                if (prev_stall)
                    check_output("stall_hold_pix", out_pix, held_pix);
                held_pix   = out_pix;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
                check_output("in_ready", 64'(in_ready), 64'd1);
                if (out_valid) begin
                    check_output("xfer_load_L", 64'(out_load_L), 64'd0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_out: actual=%0h required=no output", out_pix);
                    end else begin
                        e = sb.pop_front();
                        check_output("out_pix", out_pix, e.pix);
                        check_output("out_last", 64'(out_last), 64'(e.last));
                        check_output("latency", 64'(cyc - e.acc_cyc),
                                     64'(3 + stall_cnt - e.acc_stall));
                    end
                end else begin
                    check_output("idle_load_L", 64'(out_load_L), 64'd1);
                end
            end
        end
        prev_reset = reset;
    end

    task automatic apply_stimulus(input logic [119:0] row, input logic [1:0] frac);
        bit done;
        done     = 1'b0;
        in_row   = row;
        in_frac  = frac;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clock);
            done = in_ready && !reset;
            @(posedge clock);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: actual in_ready=0 required=1");
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            @(posedge clock);
            #1;
        end
        repeat (2) @(posedge clock);
        #1;
        check_output("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [119:0] row;
        logic [1:0]   fr;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        in_frac   = 2'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        $display("[TB] ramp row, integer position");
        for (int k = 0; k < 15; k++) row[8*k +: 8] = 8'(k);
        apply_stimulus(row, 2'd0);
        drain();

        $display("[TB] half-pel clip high and low");
        pulse_reset(1);
        row = '0;
        row[63:0] = {8'd0, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0};
        apply_stimulus(row, 2'd2);
        row[63:0] = {8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255};
        apply_stimulus(row, 2'd1);
        drain();

        $display("[TB] constant rows across positions");
        for (int f = 0; f < 4; f++) begin
            pulse_reset(1);
            apply_stimulus({15{8'd100}}, 2'(f));
            drain();
        end

        $display("[TB] sixteen rows, frac latch per block");
        pulse_reset(1);
        for (int r = 0; r < 16; r++) begin
            if (r == 0) fr = 2'd1;
            else if (r < 8) fr = 2'd2;
            else if (r == 8) fr = 2'd3;
            else fr = 2'($urandom);
            apply_stimulus(rand_row(1'b0), fr);
        end
        drain();

        $display("[TB] five-cycle output stall mid-stream");
        fork
            begin
                for (int r = 0; r < 12; r++)
                    apply_stimulus(rand_row(r[0]), 2'($urandom));
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clock);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] reset mid-block with rows in flight");
        for (int r = 0; r < 5; r++)
            apply_stimulus(rand_row(1'b0), 2'd2);
        in_row   = rand_row(1'b0);
        in_frac  = 2'd1;
        in_valid = 1'b1;
        pulse_reset(1);
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        apply_stimulus(rand_row(1'b1), 2'd3);
        for (int r = 0; r < 8; r++)
            apply_stimulus(rand_row(1'b0), 2'($urandom));
        drain();

        $display("[TB] randomized traffic with random back-pressure");
        rand_done = 1'b0;
        fork
            begin
                for (int r = 0; r < 60; r++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge clock);
                        #1;
                    end
                    apply_stimulus(rand_row($urandom_range(0, 2) == 0), 2'($urandom));
                end
                in_valid  = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
